// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring division
// with a short path for divide-by-zero, signed overflow and bad op selects.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_rem,
    input  logic             op_remu,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dmag, result_q;
    logic [CW-1:0]    cnt;
    logic             want_rem, neg_q, neg_r;

    // Request decode, only meaningful while accepting
    logic             accept, onehot, req_signed, req_rem, a_neg, b_neg;
    logic             div_zero, ovf, corner;
    logic [WIDTH-1:0] a_mag, b_mag, corner_val;

    assign accept     = start_valid & (state == IDLE) & ~flush;
    assign onehot     = $onehot({op_div, op_divu, op_rem, op_remu});
    assign req_signed = op_div | op_rem;
    assign req_rem    = op_rem | op_remu;
    assign a_neg      = req_signed & dividend[WIDTH-1];
    assign b_neg      = req_signed & divisor[WIDTH-1];
    assign a_mag      = a_neg ? -dividend : dividend;
    assign b_mag      = b_neg ? -divisor : divisor;
    assign div_zero   = (divisor == '0);
    assign ovf        = req_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
    assign corner     = ~onehot | div_zero | ovf;

    always_comb begin
        corner_val = '0;
        if (!onehot)       corner_val = '0;
        else if (div_zero) corner_val = req_rem ? dividend : '1;
        else if (ovf)      corner_val = req_rem ? '0 : dividend;
    end

    // One restoring step; the extra bit keeps the shifted remainder exact
    // when the divisor magnitude uses the full width.
    logic [WIDTH:0] partial, trial;
    assign partial = {rem, quo[WIDTH-1]};
    assign trial   = partial - {1'b0, dmag};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = corner ? DONE : CALC;
            CALC: if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            cnt      <= '0;
            want_rem <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                rem      <= '0;
                quo      <= a_mag;
                dmag     <= b_mag;
                cnt      <= '0;
                want_rem <= req_rem;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                if (corner) result_q <= corner_val;
            end else if (state == CALC) begin
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                rem <= trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt <= cnt + 1'b1;
            end else if (state == FIX && !flush) begin
                result_q <= want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
            end
        end
    end

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign result       = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table for ops and corner cases,
// plus hand sequences for backpressure, flush and asynchronous reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid, start_ready;
    logic        op_div, op_divu, op_rem, op_remu;
    logic [31:0] dividend, divisor, result;
    logic        flush, result_valid, result_ready, busy;

    int passed = 0;
    int total  = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_div(op_div), .op_divu(op_divu), .op_rem(op_rem), .op_remu(op_remu),
        .dividend(dividend), .divisor(divisor),
        .flush(flush),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // op is {div, divu, rem, remu}; lat = edges after the accept edge
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [7:0]  lat;
    } vec_t;

    localparam logic [3:0] DIV = 4'b1000, DIVU = 4'b0100, REM = 4'b0010, REMU = 4'b0001;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        {op_div, op_divu, op_rem, op_remu} = op;
        dividend    = a;
        divisor     = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = ~a;
        divisor     = ~b;
        {op_div, op_divu, op_rem, op_remu} = 4'b1111;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  ok;

        vecs[0]  = '{op: DIVU, a: 32'd100,       b: 32'd7,         e: 32'd14,        lat: 8'd33};
        vecs[1]  = '{op: REMU, a: 32'd100,       b: 32'd7,         e: 32'd2,         lat: 8'd33};
        vecs[2]  = '{op: DIV,  a: -32'sd100,     b: 32'd7,         e: 32'hFFFFFFF2,  lat: 8'd33};
        vecs[3]  = '{op: REM,  a: -32'sd100,     b: 32'd7,         e: 32'hFFFFFFFE,  lat: 8'd33};
        vecs[4]  = '{op: REM,  a: 32'd100,       b: -32'sd7,       e: 32'd2,         lat: 8'd33};
        vecs[5]  = '{op: DIVU, a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  e: 32'd1,         lat: 8'd33};
        vecs[6]  = '{op: DIV,  a: -32'sd7,       b: -32'sd2,       e: 32'd3,         lat: 8'd33};
        vecs[7]  = '{op: REM,  a: -32'sd7,       b: -32'sd2,       e: 32'hFFFFFFFF,  lat: 8'd33};
        vecs[8]  = '{op: DIV,  a: 32'h80000000,  b: 32'd2,         e: 32'hC0000000,  lat: 8'd33};
        vecs[9]  = '{op: DIVU, a: 32'hFFFFFFFF,  b: 32'd10,        e: 32'h19999999,  lat: 8'd33};
        vecs[10] = '{op: REMU, a: 32'hFFFFFFFF,  b: 32'd10,        e: 32'd5,         lat: 8'd33};
        vecs[11] = '{op: REMU, a: 32'hFFFFFFFE,  b: 32'hFFFFFFFF,  e: 32'hFFFFFFFE,  lat: 8'd33};
        vecs[12] = '{op: DIV,  a: 32'd5,         b: 32'd0,         e: 32'hFFFFFFFF,  lat: 8'd0};
        vecs[13] = '{op: REMU, a: 32'h1234,      b: 32'd0,         e: 32'h1234,      lat: 8'd0};
        vecs[14] = '{op: DIV,  a: 32'h80000000,  b: 32'hFFFFFFFF,  e: 32'h80000000,  lat: 8'd0};
        vecs[15] = '{op: REM,  a: 32'h80000000,  b: 32'hFFFFFFFF,  e: 32'd0,         lat: 8'd0};
        vecs[16] = '{op: 4'b0011, a: 32'd10,     b: 32'd3,         e: 32'd0,         lat: 8'd0};
        vecs[17] = '{op: 4'b0000, a: 32'd10,     b: 32'd3,         e: 32'd0,         lat: 8'd0};

        rst_n = 1'b0; start_valid = 1'b0; flush = 1'b0; result_ready = 1'b1;
        {op_div, op_divu, op_rem, op_remu} = 4'b0000;
        dividend = '0; divisor = '0;
        #1;
        chk("reset start_ready", {31'd0, start_ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(n);
            chk($sformatf("vec%0d latency", i), n, {24'd0, vecs[i].lat});
            chk($sformatf("vec%0d result", i), result, vecs[i].e);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ready after", i), {30'd0, result_valid, start_ready}, 32'd1);
        end

        // Backpressure: result and handshake state frozen while result_ready low
        result_ready = 1'b0;
        issue(DIVU, 32'd100, 32'd7);
        wait_valid(n);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!result_valid || result !== 32'd14 || start_ready) ok = 1'b0;
        end
        chk("backpressure hold", {31'd0, ok}, 32'd1);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("backpressure release", {30'd0, result_valid, start_ready}, 32'd1);

        // Flush mid-CALC
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush to idle", {30'd0, busy, start_ready}, 32'd1);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid) ok = 1'b0;
        end
        chk("flush no result", {31'd0, ok}, 32'd1);

        // Flush together with start_valid: no accept
        @(negedge clk);
        {op_div, op_divu, op_rem, op_remu} = DIVU;
        dividend = 32'd50; divisor = 32'd5;
        start_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush = 1'b0;
        chk("flush blocks accept", {30'd0, busy, start_ready}, 32'd1);

        // Asynchronous reset mid-CALC, then a normal op
        issue(DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset start_ready", {31'd0, start_ready}, 32'd1);
        chk("async reset result_valid", {31'd0, result_valid}, 32'd0);
        chk("async reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(DIVU, 32'd9, 32'd3);
        wait_valid(n);
        chk("post-reset latency", n, 32'd33);
        chk("post-reset result", result, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
